grf_sb: RTL and testbench

GRF_SB -- requirements
Module: grf_sb

---
 rtl/grf_sb_if.sv | 31 +++
 rtl/grf_sb.sv | 74 +++++++
 tb/tb_grf_sb.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/grf_sb_if.sv
// rtl/grf_sb_if.sv - read, write and issue-marker signal bundle for grf_sb
interface grf_sb_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic          busy1;
    logic          busy2;
    logic          we0;
    logic [AW-1:0] a30;
    logic [DW-1:0] wd0;
    logic          we1;
    logic [AW-1:0] a31;
    logic [DW-1:0] wd1;
    logic          set;
    logic [AW-1:0] sa;
    logic [15:0]   wcnt;

    modport master (
        output a1, a2, we0, a30, wd0, we1, a31, wd1, set, sa,
        input  rd1, rd2, busy1, busy2, wcnt
    );

    modport slave (
        input  a1, a2, we0, a30, wd0, we1, a31, wd1, set, sa,
        output rd1, rd2, busy1, busy2, wcnt
    );
endinterface

// File: rtl/grf_sb.sv
// rtl/grf_sb.sv - 2R/2W register file with pending-write scoreboard; GRF_SB_BYPASS_EN enables write-to-read bypass
module grf_sb #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic     clk,
    input  logic     reset,
    grf_sb_if.slave  bus
);
    localparam int NREG = 2**AW;

    logic [DW-1:0]   regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic [15:0]     wcnt_q;
    logic            commit0;
    logic            commit1;

    // Port 0 wins a same-address collision; the dropped port 1 write is neither stored nor counted.
    always_comb begin
        commit0 = bus.we0 && (bus.a30 != '0);
        commit1 = bus.we1 && (bus.a31 != '0) && !(commit0 && (bus.a31 == bus.a30));
    end

    // Commits retire the pending flag, then a same-cycle issue marker re-arms it for the new producer.
    always_comb begin
        busy_next = busy;
        if (commit0) busy_next[bus.a30] = 1'b0;
        if (commit1) busy_next[bus.a31] = 1'b0;
        if (bus.set && (bus.sa != '0)) busy_next[bus.sa] = 1'b1;
    end

    // Register storage, scoreboard and commit counter; reset overrides all same-cycle activity.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            busy   <= '0;
            wcnt_q <= '0;
        end else begin
            if (commit1) regs[bus.a31] <= bus.wd1;
            if (commit0) regs[bus.a30] <= bus.wd0;
            busy   <= busy_next;
            wcnt_q <= wcnt_q + {15'd0, commit0} + {15'd0, commit1};
        end
    end

    // Returns {busy, data} for one read address; register 0 is hardwired to zero and never busy.
    function automatic logic [DW:0] read_port(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        logic          b;
        d = (a == '0) ? {DW{1'b0}} : regs[a];
        b = (a == '0) ? 1'b0 : busy[a];
`ifdef GRF_SB_BYPASS_EN
        if (reset && (a != '0)) begin
            if (commit0 && (bus.a30 == a)) begin
                d = bus.wd0;
                b = bus.set && (bus.sa == a);
            end else if (commit1 && (bus.a31 == a)) begin
                d = bus.wd1;
                b = bus.set && (bus.sa == a);
            end
        end
`endif
        return {b, d};
    endfunction

    // Zero-latency read ports.
    always_comb begin
        {bus.busy1, bus.rd1} = read_port(bus.a1);
        {bus.busy2, bus.rd2} = read_port(bus.a2);
    end

    assign bus.wcnt = wcnt_q;
endmodule

// File: tb/tb_grf_sb.sv
// tb/tb_grf_sb.sv - self-checking bench for grf_sb (vector table, corner sequences, random vs model)
module tb_grf_sb;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NREG = 32;

    logic clk;
    logic reset;
    grf_sb_if #(.DW(DW), .AW(AW)) bus ();

    grf_sb #(.DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural reference state
    logic [31:0] m_reg  [NREG];
    bit          m_busy [NREG];
    int          m_wcnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Apply this cycle's requests to the model as the coming clock edge would.
    task automatic model_step();
        bit hit [NREG];
        int n;
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                m_reg[i] = '0;
                m_busy[i] = 0;
            end
            m_wcnt = 0;
        end else begin
            for (int i = 0; i < NREG; i++) hit[i] = 0;
            // secondary first so the primary port overwrites it on a collision
            if (bus.we1 && bus.a31 != 0) begin
                m_reg[bus.a31] = bus.wd1;
                hit[bus.a31] = 1;
            end
            if (bus.we0 && bus.a30 != 0) begin
                m_reg[bus.a30] = bus.wd0;
                hit[bus.a30] = 1;
            end
            n = 0;
            for (int i = 0; i < NREG; i++) begin
                if (hit[i]) begin
                    n++;
                    m_busy[i] = 0;
                end
            end
            if (bus.set && bus.sa != 0) m_busy[bus.sa] = 1;
            m_wcnt = (m_wcnt + n) % 65536;
        end
    endtask

    // What a read of address a should show right now, given stored model state and current inputs.
    task automatic exp_read(input logic [4:0] a, output logic [31:0] d, output logic b);
        d = (a == 0) ? 32'd0 : m_reg[a];
        b = (a == 0) ? 1'b0 : m_busy[a];
`ifdef GRF_SB_BYPASS_EN
        if (reset && a != 0) begin
            if (bus.we0 && bus.a30 == a) begin
                d = bus.wd0;
                b = bus.set && bus.sa == a;
            end else if (bus.we1 && bus.a31 == a) begin
                d = bus.wd1;
                b = bus.set && bus.sa == a;
            end
        end
`endif
    endtask

    task automatic idle();
        bus.we0 = 0; bus.a30 = 0; bus.wd0 = 0;
        bus.we1 = 0; bus.a31 = 0; bus.wd1 = 0;
        bus.set = 0; bus.sa = 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] d;
        logic        b;
        exp_read(bus.a1, d, b);
        chk({tag, "_rd1"}, bus.rd1, d);
        chk({tag, "_busy1"}, {31'd0, bus.busy1}, {31'd0, b});
        exp_read(bus.a2, d, b);
        chk({tag, "_rd2"}, bus.rd2, d);
        chk({tag, "_busy2"}, {31'd0, bus.busy2}, {31'd0, b});
        chk({tag, "_wcnt"}, {16'd0, bus.wcnt}, m_wcnt[31:0]);
    endtask

    typedef struct {
        bit          rst_n;
        bit          we0;
        logic [4:0]  a30;
        logic [31:0] wd0;
        bit          we1;
        logic [4:0]  a31;
        logic [31:0] wd1;
        bit          set;
        logic [4:0]  sa;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e_rd1;
        bit          e_busy1;
        logic [31:0] e_rd2;
        logic [15:0] e_wcnt;
    } vec_t;

    vec_t vecs [7];

    initial begin
        //          rst we0 a30 wd0           we1 a31 wd1     set sa  a1  a2  e_rd1         eb1 e_rd2   e_wcnt
        vecs[0] = '{0,  1,  3,  32'hAAAA5555, 0,  0,  0,      0,  0,  3,  5,  32'h0,        0,  32'h0,  16'd0};
        vecs[1] = '{1,  1,  5,  32'h11,       1,  5,  32'h22, 0,  0,  5,  3,  32'h11,       0,  32'h0,  16'd1};
        vecs[2] = '{1,  0,  0,  0,            0,  0,  0,      1,  7,  7,  5,  32'h0,        1,  32'h11, 16'd1};
        vecs[3] = '{1,  0,  0,  0,            1,  7,  32'h99, 1,  7,  7,  0,  32'h99,       1,  32'h0,  16'd2};
        vecs[4] = '{1,  1,  0,  32'hFFFFFFFF, 0,  0,  0,      1,  0,  0,  7,  32'h0,        0,  32'h99, 16'd2};
        vecs[5] = '{1,  1,  7,  32'h1234,     0,  0,  0,      0,  0,  7,  0,  32'h1234,     0,  32'h0,  16'd3};
        vecs[6] = '{1,  1,  8,  32'hA,        1,  9,  32'hB,  0,  0,  8,  9,  32'hA,        0,  32'hB,  16'd5};

        idle();
        bus.a1 = 0;
        bus.a2 = 0;
        reset = 0;
        #1;
        tick();
        tick();
        reset = 1;

        // reset state across every address
        for (int i = 0; i < NREG; i++) begin
            bus.a1 = 5'(i);
            bus.a2 = 5'(NREG - 1 - i);
            #1;
            chk("reset_rd1", bus.rd1, 32'd0);
            chk("reset_busy2", {31'd0, bus.busy2}, 32'd0);
        end
        chk("reset_wcnt", {16'd0, bus.wcnt}, 32'd0);

        // directed vector table: apply one cycle, then read back with ports idle
        for (int v = 0; v < 7; v++) begin
            reset = vecs[v].rst_n;
            bus.we0 = vecs[v].we0; bus.a30 = vecs[v].a30; bus.wd0 = vecs[v].wd0;
            bus.we1 = vecs[v].we1; bus.a31 = vecs[v].a31; bus.wd1 = vecs[v].wd1;
            bus.set = vecs[v].set; bus.sa = vecs[v].sa;
            #1;
            tick();
            reset = 1;
            idle();
            bus.a1 = vecs[v].a1;
            bus.a2 = vecs[v].a2;
            #1;
            chk($sformatf("vec%0d_rd1", v), bus.rd1, vecs[v].e_rd1);
            chk($sformatf("vec%0d_busy1", v), {31'd0, bus.busy1}, {31'd0, vecs[v].e_busy1});
            chk($sformatf("vec%0d_rd2", v), bus.rd2, vecs[v].e_rd2);
            chk($sformatf("vec%0d_wcnt", v), {16'd0, bus.wcnt}, {16'd0, vecs[v].e_wcnt});
        end

        // same-cycle write and read of register 9 (holds 0xB), with and without an issue marker
        bus.a2 = 9;
        bus.we0 = 1; bus.a30 = 9; bus.wd0 = 32'hDEAD;
        #1;
`ifdef GRF_SB_BYPASS_EN
        chk("byp_rd2_same", bus.rd2, 32'hDEAD);
`else
        chk("byp_rd2_same", bus.rd2, 32'hB);
`endif
        chk("byp_busy2_same", {31'd0, bus.busy2}, 32'd0);
        bus.set = 1; bus.sa = 9;
        #1;
`ifdef GRF_SB_BYPASS_EN
        chk("byp_busy2_set", {31'd0, bus.busy2}, 32'd1);
`else
        chk("byp_busy2_set", {31'd0, bus.busy2}, 32'd0);
`endif
        tick();
        idle();
        #1;
        chk("byp_rd2_next", bus.rd2, 32'hDEAD);
        chk("byp_busy2_next", {31'd0, bus.busy2}, 32'd1);

        // bypass must not apply while reset is low
        reset = 0;
        bus.we0 = 1; bus.a30 = 9; bus.wd0 = 32'h5A5A;
        #1;
        chk("rst_nobyp_rd2", bus.rd2, 32'hDEAD);
        tick();
        reset = 1;
        idle();
        #1;
        chk("rst_nobyp_after", bus.rd2, 32'd0);

        // randomized traffic against the model, small address range to provoke collisions
        for (int c = 0; c < 400; c++) begin
            reset   = ($urandom_range(0, 29) != 0);
            bus.we0 = $urandom_range(0, 1);
            bus.a30 = 5'($urandom_range(0, 7));
            bus.wd0 = $urandom;
            bus.we1 = $urandom_range(0, 1);
            bus.a31 = 5'($urandom_range(0, 7));
            bus.wd1 = $urandom;
            bus.set = $urandom_range(0, 1);
            bus.sa  = 5'($urandom_range(0, 7));
            bus.a1  = 5'($urandom_range(0, 7));
            bus.a2  = 5'($urandom_range(0, 31));
            #1;
            check_all($sformatf("rnd%0d", c));
            tick();
        end
        reset = 1;
        idle();
        #1;
        check_all("rnd_end");

        // counter wrap: clear, climb to 0xFFFE with dual writes, then one more dual write
        reset = 0;
        tick();
        reset = 1;
        bus.we0 = 1; bus.a30 = 1; bus.wd0 = 32'h1;
        bus.we1 = 1; bus.a31 = 2; bus.wd1 = 32'h2;
        for (int c = 0; c < 32767; c++) tick();
        chk("wcnt_fffe", {16'd0, bus.wcnt}, 32'h0000FFFE);
        tick();
        chk("wcnt_wrap", {16'd0, bus.wcnt}, 32'h00000000);
        chk("wcnt_model", {16'd0, bus.wcnt}, m_wcnt[31:0]);
        idle();
        bus.a1 = 1;
        bus.a2 = 2;
        #1;
        chk("wrap_rd1", bus.rd1, 32'h1);
        chk("wrap_rd2", bus.rd2, 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
